amiga_clk_altera: RTL and testbench

- Digital clock-synthesis block that stands in for the vendor PLL behind the Amiga clock generator.
- From one reference clock it derives three square-wave outputs using phase accumulators (NCOs):
  - c0: SDRAM controller clock.
  - c1: 28 MHz-class chipset clock.
  - c2: SDRAM pin clock, same frequency as c0 with a fixed phase lag.
- Asserts locked after a programmable settle time.

---
 rtl/amiga_clk_altera.sv | 125 ++++++++++++
 tb/tb_amiga_clk_altera.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/amiga_clk_altera.sv
// amiga_clk_altera: NCO-based stand-in for the Amiga clock PLL (c0 SDRAM ctrl, c1 chipset, c2 SDRAM pin).
// Define AMIGA_CLK_CE_OUT_EN to add c0_ce/c1_ce/c2_ce rising-edge pulse outputs.
module amiga_clk_altera #(
    parameter int unsigned      ACC_W       = 32,
    parameter logic [ACC_W-1:0] C0_INC      = 32'h4000_0000,
    parameter logic [ACC_W-1:0] C1_INC      = 32'h1000_0000,
    parameter logic [ACC_W-1:0] C2_PHASE    = 32'h9800_0000,
    parameter int unsigned      LOCK_CYCLES = 16
) (
    input  logic inclk0,
    input  logic areset,
    output logic c0,
    output logic c1,
    output logic c2,
`ifdef AMIGA_CLK_CE_OUT_EN
    output logic c0_ce,
    output logic c1_ce,
    output logic c2_ce,
`endif
    output logic locked
);

    localparam int unsigned      CNT_W     = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);

    if (ACC_W < 8) begin : g_bad_acc_w
        $error("amiga_clk_altera: ACC_W must be at least 8");
    end
    if (LOCK_CYCLES < 1) begin : g_bad_lock
        $error("amiga_clk_altera: LOCK_CYCLES must be at least 1");
    end

    typedef enum logic {
        ST_ACQUIRE,
        ST_LOCKED
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [ACC_W-1:0]   acc0_q,  acc0_d;
    logic [ACC_W-1:0]   acc1_q,  acc1_d;
    logic [ACC_W-1:0]   acc2_q,  acc2_d;

    // acc2 is kept as its own register equal to acc0 + C2_PHASE so that c2 needs
    // no adder after the flops; it advances by C0_INC in lockstep with acc0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc0_d  = acc0_q;
        acc1_d  = acc1_q;
        acc2_d  = acc2_q;
        unique case (state_q)
            ST_ACQUIRE: begin
                acc0_d = '0;
                acc1_d = '0;
                acc2_d = C2_PHASE;
                if (cnt_q == LOCK_LAST) begin
                    state_d = ST_LOCKED;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_LOCKED: begin
                acc0_d = acc0_q + C0_INC;
                acc1_d = acc1_q + C1_INC;
                acc2_d = acc2_q + C0_INC;
            end
            default: begin
                state_d = ST_ACQUIRE;
            end
        endcase
    end

    always_ff @(posedge inclk0) begin
        if (areset) begin
            state_q <= ST_ACQUIRE;
            cnt_q   <= '0;
            acc0_q  <= '0;
            acc1_q  <= '0;
            acc2_q  <= C2_PHASE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc0_q  <= acc0_d;
            acc1_q  <= acc1_d;
            acc2_q  <= acc2_d;
        end
    end

    always_comb begin
        locked = (state_q == ST_LOCKED);
        c0     = locked & acc0_q[ACC_W-1];
        c1     = locked & acc1_q[ACC_W-1];
        c2     = locked & acc2_q[ACC_W-1];
    end

`ifdef AMIGA_CLK_CE_OUT_EN
    logic [2:0] ce_q, ce_d;

    // Pulse is computed from next-state values so it lands in the same cycle the output first reads 1.
    always_comb begin
        ce_d = '0;
        if (state_d == ST_LOCKED) begin
            ce_d[0] = acc0_d[ACC_W-1] & ~c0;
            ce_d[1] = acc1_d[ACC_W-1] & ~c1;
            ce_d[2] = acc2_d[ACC_W-1] & ~c2;
        end
    end

    always_ff @(posedge inclk0) begin
        if (areset) begin
            ce_q <= '0;
        end else begin
            ce_q <= ce_d;
        end
    end

    always_comb begin
        c0_ce = ce_q[0];
        c1_ce = ce_q[1];
        c2_ce = ce_q[2];
    end
`endif

endmodule

// File: tb/tb_amiga_clk_altera.sv
// Testbench for amiga_clk_altera: directed vector table, random resets against a phase model,
// and long-run period/duty sequences on a default and a non-default instance.
module tb_amiga_clk_altera;

    logic clk = 1'b0;
    logic areset = 1'b1;
    logic a_c0, a_c1, a_c2, a_locked;
    logic b_c0, b_c1, b_c2, b_locked;
`ifdef AMIGA_CLK_CE_OUT_EN
    logic a_c0_ce, a_c1_ce, a_c2_ce;
    logic b_c0_ce, b_c1_ce, b_c2_ce;
`endif

    always #5 clk = ~clk;

    amiga_clk_altera dut_a (
        .inclk0 (clk),
        .areset (areset),
        .c0     (a_c0),
        .c1     (a_c1),
        .c2     (a_c2),
`ifdef AMIGA_CLK_CE_OUT_EN
        .c0_ce  (a_c0_ce),
        .c1_ce  (a_c1_ce),
        .c2_ce  (a_c2_ce),
`endif
        .locked (a_locked)
    );

    amiga_clk_altera #(
        .C0_INC      (32'h2AAA_AAAB),
        .C1_INC      (32'h0000_0000),
        .C2_PHASE    (32'h4000_0000),
        .LOCK_CYCLES (1)
    ) dut_b (
        .inclk0 (clk),
        .areset (areset),
        .c0     (b_c0),
        .c1     (b_c1),
        .c2     (b_c2),
`ifdef AMIGA_CLK_CE_OUT_EN
        .c0_ce  (b_c0_ce),
        .c1_ce  (b_c1_ce),
        .c2_ce  (b_c2_ce),
`endif
        .locked (b_locked)
    );

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned k = 0;          // edges with areset=0 since the last reset edge
    logic [3:0]  prev_a = '0;
    logic [3:0]  prev_b = '0;

    typedef struct {
        bit         rst;
        logic [3:0] exp;         // {locked, c0, c1, c2}
    } vec_t;
    vec_t vecs[$];

    // Expected {locked,c0,c1,c2} after kk reset-free edges: n = kk - lock edges increments done.
    function automatic logic [3:0] model_outs(input int unsigned kk, input int unsigned lc,
                                              input logic [31:0] i0, input logic [31:0] i1,
                                              input logic [31:0] ph);
        logic [63:0] n, p0, p1;
        logic [31:0] a0, a1, a2;
        if (kk < lc) return 4'b0000;
        n  = 64'(kk - lc);
        p0 = n * 64'(i0);
        p1 = n * 64'(i1);
        a0 = p0[31:0];
        a1 = p1[31:0];
        a2 = a0 + ph;
        return {1'b1, a0[31], a1[31], a2[31]};
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
        end
    endtask

    task automatic step(input bit rst);
        logic [3:0] ea, eb;
        areset = rst;
        @(posedge clk);
        k = rst ? 0 : k + 1;
        #1;
        ea = model_outs(k, 16, 32'h4000_0000, 32'h1000_0000, 32'h9800_0000);
        eb = model_outs(k, 1,  32'h2AAA_AAAB, 32'h0000_0000, 32'h4000_0000);
        chk("model_a", {a_locked, a_c0, a_c1, a_c2}, ea);
        chk("model_b", {b_locked, b_c0, b_c1, b_c2}, eb);
`ifdef AMIGA_CLK_CE_OUT_EN
        chk("ce_a", {1'b0, a_c0_ce, a_c1_ce, a_c2_ce}, {1'b0, ea[2:0] & ~prev_a[2:0]});
        chk("ce_b", {1'b0, b_c0_ce, b_c1_ce, b_c2_ce}, {1'b0, eb[2:0] & ~prev_b[2:0]});
`endif
        prev_a = ea;
        prev_b = eb;
    endtask

    function automatic void add(input bit r, input logic [3:0] e);
        vecs.push_back('{rst: r, exp: e});
    endfunction

    initial begin
        logic pb0, pa1, first_b0, first_a1;
        int   run_b0, run_a1, rises_b0, rises_a1, bad_b0, bad_a1, high_a1;
        int   ce_pulses, ce_double;
        logic pce;

        // Directed table on dut_a: reset, 16-edge lock, first increments, mid-run reset while c0=1, relock.
        for (int i = 0; i < 5; i++)  add(1'b1, 4'b0000);
        for (int i = 0; i < 15; i++) add(1'b0, 4'b0000);
        add(1'b0, 4'b1001);  // lock edge: acc0=0, c2 from 0x98..
        add(1'b0, 4'b1001);  // n=1
        add(1'b0, 4'b1100);  // n=2
        add(1'b0, 4'b1100);  // n=3
        add(1'b0, 4'b1001);  // n=4
        add(1'b0, 4'b1001);  // n=5
        add(1'b0, 4'b1100);  // n=6
        add(1'b0, 4'b1100);  // n=7
        add(1'b0, 4'b1011);  // n=8: c1 first high
        add(1'b0, 4'b1011);  // n=9
        add(1'b0, 4'b1110);  // n=10
        add(1'b1, 4'b0000);  // reset while c0=1
        for (int i = 0; i < 15; i++) add(1'b0, 4'b0000);
        add(1'b0, 4'b1001);
        add(1'b0, 4'b1001);

        foreach (vecs[i]) begin
            step(vecs[i].rst);
            chk($sformatf("vec%0d", i), {a_locked, a_c0, a_c1, a_c2}, vecs[i].exp);
        end

        // Random reset pulses checked every edge against the phase model.
        for (int i = 0; i < 3000; i++) step($urandom_range(0, 59) == 0);

        // Long run: c0 of dut_b at ~f/6, c1 of dut_a at f/16.
        step(1'b1);
        for (int w = 0; w < 40 && !(a_locked && b_locked); w++) step(1'b0);
        chk_int("lock_wait", int'(a_locked && b_locked), 1, 1);

        pb0 = b_c0;  pa1 = a_c1;
        run_b0 = 1;  run_a1 = 1;
        first_b0 = 1'b1;  first_a1 = 1'b1;
        rises_b0 = 0; rises_a1 = 0; bad_b0 = 0; bad_a1 = 0; high_a1 = 0;
        ce_pulses = 0; ce_double = 0; pce = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            step(1'b0);
            if (b_c0 != pb0) begin
                if (!first_b0 && (run_b0 < 2 || run_b0 > 3)) bad_b0++;
                if (b_c0) rises_b0++;
                first_b0 = 1'b0;
                run_b0 = 1;
            end else begin
                run_b0++;
            end
            if (a_c1 != pa1) begin
                if (!first_a1 && run_a1 != 8) bad_a1++;
                if (a_c1) rises_a1++;
                first_a1 = 1'b0;
                run_a1 = 1;
            end else begin
                run_a1++;
            end
            if (a_c1) high_a1++;
`ifdef AMIGA_CLK_CE_OUT_EN
            if (a_c0_ce) ce_pulses++;
            if (a_c0_ce && pce) ce_double++;
            pce = a_c0_ce;
`endif
            pb0 = b_c0;
            pa1 = a_c1;
        end
        chk_int("f6_rises", rises_b0, 999, 1001);
        chk_int("f6_bad_runs", bad_b0, 0, 0);
        chk_int("c1_rises", rises_a1, 375, 375);
        chk_int("c1_high_cycles", high_a1, 3000, 3000);
        chk_int("c1_bad_runs", bad_a1, 0, 0);
`ifdef AMIGA_CLK_CE_OUT_EN
        chk_int("c0_ce_pulses", ce_pulses, 1500, 1500);
        chk_int("c0_ce_double", ce_double, 0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
